// File: rtl/stopwatch_pkg.sv
// Shared FSM encoding and BCD limits for the minutes:seconds stopwatch controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSED = 2'd1,
    ADJUST = 2'd2
  } sw_state_e;

  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] UNITS_MAX    = 4'd9;

  function automatic logic bcd_at_max(input logic [3:0] tens, input logic [3:0] units,
                                      input logic [3:0] max_tens, input logic [3:0] max_units);
    return (tens == max_tens) && (units == max_units);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_field_counter.sv
// Two-digit BCD counter with synchronous clear; wrap pulses combinationally on the increment
// that rolls the field from its maximum back to 00, so a following field can carry the same edge.
module bcd_field_counter
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  input  logic [3:0] max_tens,
  input  logic [3:0] max_units,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       wrap
);

  logic [3:0] tens_q, tens_d;
  logic [3:0] units_q, units_d;
  logic       at_max_s;

  assign at_max_s = bcd_at_max(tens_q, units_q, max_tens, max_units);
  assign wrap     = inc && !clr && at_max_s;

  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    if (clr) begin
      tens_d  = 4'd0;
      units_d = 4'd0;
    end else if (inc) begin
      if (at_max_s) begin
        tens_d  = 4'd0;
        units_d = 4'd0;
      end else if (units_q >= UNITS_MAX) begin
        tens_d  = tens_q + 4'd1;
        units_d = 4'd0;
      end else begin
        units_d = units_q + 4'd1;
      end
    end else begin
      units_d = units_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_q  <= 4'd0;
      units_q <= 4'd0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign tens  = tens_q;
  assign units = units_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode/count controller: input synchronisers, button edge detection,
// RUN/PAUSED/ADJUST FSM and the seconds/minutes BCD fields feeding the display driver.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MM_MAX      = 59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       btn_pause,
  input  logic       btn_reset,
  input  logic       sw_adj,
  input  logic       sw_sel,
  output logic [3:0] units,
  output logic [3:0] tens,
  output logic [3:0] hundreds,
  output logic [3:0] thousands,
  output logic       adj,
  output logic       sel,
  output logic       running
);

  localparam logic [3:0] MIN_TENS_MAX  = 4'(MM_MAX / 10);
  localparam logic [3:0] MIN_UNITS_MAX = 4'(MM_MAX % 10);

  // Bit order in the synchroniser bus: {sw_sel, sw_adj, btn_reset, btn_pause}.
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] lvl_s;
  logic [1:0] btn_prev_q;
  logic       press_pause_q, press_reset_q;
  sw_state_e  state_q, state_d;
  logic       sel_q, adj_q, running_q;
  logic       sec_inc_s, min_inc_s, sec_wrap_s;

  assign lvl_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'd0;
      btn_prev_q    <= 2'd0;
      press_pause_q <= 1'b0;
      press_reset_q <= 1'b0;
    end else begin
      sync_q[0] <= {sw_sel, sw_adj, btn_reset, btn_pause};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      btn_prev_q    <= lvl_s[1:0];
      press_pause_q <= lvl_s[0] & ~btn_prev_q[0];
      press_reset_q <= lvl_s[1] & ~btn_prev_q[1];
    end
  end

  always_comb begin
    state_d = state_q;
    if (lvl_s[2]) begin
      state_d = ADJUST;
    end else begin
      case (state_q)
        RUN:     state_d = press_pause_q ? PAUSED : RUN;
        PAUSED:  state_d = press_pause_q ? RUN : PAUSED;
        ADJUST:  state_d = PAUSED;
        default: state_d = RUN;
      endcase
    end
  end

  // Field increments use the current state and the registered sel, so a same-cycle sel change lands late.
  always_comb begin
    sec_inc_s = 1'b0;
    case (state_q)
      RUN:     sec_inc_s = tick_1hz;
      ADJUST:  sec_inc_s = tick_2hz & sel_q;
      default: sec_inc_s = 1'b0;
    endcase
  end

  assign min_inc_s = ((state_q == RUN) & sec_wrap_s) | ((state_q == ADJUST) & tick_2hz & ~sel_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      sel_q     <= 1'b0;
      adj_q     <= 1'b0;
      running_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      sel_q     <= lvl_s[3];
      adj_q     <= (state_d == ADJUST);
      running_q <= (state_d == RUN);
    end
  end

  bcd_field_counter u_seconds (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (press_reset_q),
    .inc       (sec_inc_s),
    .max_tens  (SEC_TENS_MAX),
    .max_units (UNITS_MAX),
    .tens      (tens),
    .units     (units),
    .wrap      (sec_wrap_s)
  );

  bcd_field_counter u_minutes (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (press_reset_q),
    .inc       (min_inc_s),
    .max_tens  (MIN_TENS_MAX),
    .max_units (MIN_UNITS_MAX),
    .tens      (thousands),
    .units     (hundreds),
    .wrap      ()
  );

  assign adj     = adj_q;
  assign sel     = sel_q;
  assign running = running_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: a time/latency model in plain integer arithmetic,
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_stopwatch_ctrl;

  localparam int S  = 2;
  localparam int MM = 59;
  localparam int M_PAUSED = 0;
  localparam int M_RUN    = 1;
  localparam int M_ADJ    = 2;

  typedef struct packed {
    int   sec;
    int   min;
    int   mode;
    logic sel;
  } mstate_t;

  logic       clk = 1'b0;
  logic       rst_n, tick_1hz, tick_2hz, btn_pause, btn_reset, sw_adj, sw_sel;
  logic [3:0] units, tens, hundreds, thousands;
  logic       adj, sel, running;
  logic [15:0] dig_s;

  int n_cmp = 0;
  int n_err = 0;

  mstate_t    m_q;
  logic [7:0] hp_q, hr_q, ha_q, hs_q;

  stopwatch_ctrl #(.SYNC_STAGES(S), .MM_MAX(MM)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .btn_pause(btn_pause), .btn_reset(btn_reset), .sw_adj(sw_adj), .sw_sel(sw_sel),
    .units(units), .tens(tens), .hundreds(hundreds), .thousands(thousands),
    .adj(adj), .sel(sel), .running(running)
  );

  always #5 clk = ~clk;

  assign dig_s = {thousands, hundreds, tens, units};

  // h[j] holds the raw level seen j+1 edges ago; synchroniser and press latency are read off it.
  function automatic mstate_t model_next(input mstate_t cur, input logic t1, input logic t2,
                                         input logic [7:0] hp, input logic [7:0] hr,
                                         input logic [7:0] ha, input logic [7:0] hs);
    mstate_t nx;
    logic    adj_lvl, prs_p, prs_r, sel_old;
    int      total;
    nx      = cur;
    adj_lvl = ha[S-1];
    prs_p   = hp[S] & ~hp[S+1];
    prs_r   = hr[S] & ~hr[S+1];
    sel_old = hs[S];
    if (adj_lvl) nx.mode = M_ADJ;
    else if (cur.mode == M_ADJ) nx.mode = M_PAUSED;
    else if (prs_p) nx.mode = (cur.mode == M_RUN) ? M_PAUSED : M_RUN;
    if (prs_r) begin
      nx.sec = 0;
      nx.min = 0;
    end else if (cur.mode == M_RUN && t1) begin
      total  = cur.min * 60 + cur.sec + 1;
      nx.sec = total % 60;
      nx.min = (total / 60) % (MM + 1);
    end else if (cur.mode == M_ADJ && t2) begin
      if (sel_old) nx.sec = (cur.sec + 1) % 60;
      else         nx.min = (cur.min + 1) % (MM + 1);
    end
    nx.sel = hs[S-1];
    return nx;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.sec  <= 0;
      m_q.min  <= 0;
      m_q.mode <= M_RUN;
      m_q.sel  <= 1'b0;
      hp_q <= 8'd0;
      hr_q <= 8'd0;
      ha_q <= 8'd0;
      hs_q <= 8'd0;
    end else begin
      m_q  <= model_next(m_q, tick_1hz, tick_2hz, hp_q, hr_q, ha_q, hs_q);
      hp_q <= {hp_q[6:0], btn_pause};
      hr_q <= {hr_q[6:0], btn_reset};
      ha_q <= {ha_q[6:0], sw_adj};
      hs_q <= {hs_q[6:0], sw_sel};
    end
  end

  task automatic compare_now();
    logic [18:0] act, exp;
    act = {thousands, hundreds, tens, units, adj, sel, running};
    exp = {4'(m_q.min / 10), 4'(m_q.min % 10), 4'(m_q.sec / 10), 4'(m_q.sec % 10),
           (m_q.mode == M_ADJ), m_q.sel, (m_q.mode == M_RUN)};
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL model t=%0t got {mmss,adj,sel,run}=%h expected %h", $time, act, exp);
    end
  endtask

  task automatic check_lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #2;
    compare_now();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic step(input logic t1, input logic t2);
    tick_1hz = t1;
    tick_2hz = t2;
    cycle();
    tick_1hz = 1'b0;
    tick_2hz = 1'b0;
  endtask

  task automatic ticks2(input int n);
    repeat (n) step(1'b0, 1'b1);
  endtask

  task automatic press_pause();
    btn_pause = 1'b1;
    idle(S + 3);
    btn_pause = 1'b0;
    idle(S + 2);
  endtask

  initial begin
    rst_n = 1'b0; tick_1hz = 1'b0; tick_2hz = 1'b0;
    btn_pause = 1'b0; btn_reset = 1'b0; sw_adj = 1'b0; sw_sel = 1'b0;
    idle(3);
    check_lit("reset_digits", 32'(dig_s), 32'h0000);
    check_lit("reset_flags", {29'd0, adj, sel, running}, 32'h1);
    rst_n = 1'b1;
    idle(2);

    // 1: count through a full minute.
    repeat (59) step(1'b1, 1'b0);
    check_lit("count_0059", 32'(dig_s), 32'h0059);
    step(1'b1, 1'b0);
    check_lit("count_0100", 32'(dig_s), 32'h0100);
    check_lit("count_running", {31'd0, running}, 32'h1);

    // 2: preset 59:59 and let RUN wrap the minutes.
    sw_adj = 1'b1; sw_sel = 1'b1; idle(S + 2);
    ticks2(59);
    sw_sel = 1'b0; idle(S + 2);
    ticks2(58);
    check_lit("preset_5959", 32'(dig_s), 32'h5959);
    sw_adj = 1'b0; idle(S + 2);
    press_pause();
    step(1'b1, 1'b0);
    check_lit("wrap_0000", 32'(dig_s), 32'h0000);

    // 3: pause ignores ticks at 03:07.
    sw_adj = 1'b1; sw_sel = 1'b0; idle(S + 2);
    ticks2(3);
    sw_sel = 1'b1; idle(S + 2);
    ticks2(7);
    sw_adj = 1'b0; idle(S + 2);
    press_pause();
    check_lit("run_0307", 32'(dig_s), 32'h0307);
    press_pause();
    repeat (5) step(1'b1, 1'b0);
    check_lit("paused_0307", 32'(dig_s), 32'h0307);
    check_lit("paused_running", {31'd0, running}, 32'h0);
    press_pause();
    step(1'b1, 1'b0);
    check_lit("resume_0308", 32'(dig_s), 32'h0308);

    // 4: adjust wraps seconds without carry, then minutes.
    btn_reset = 1'b1; idle(S + 3);
    btn_reset = 1'b0; idle(S + 2);
    check_lit("clear_0000", 32'(dig_s), 32'h0000);
    sw_adj = 1'b1; sw_sel = 1'b1; idle(S + 2);
    ticks2(58);
    check_lit("adj_0058", 32'(dig_s), 32'h0058);
    ticks2(3);
    check_lit("adj_0001", 32'(dig_s), 32'h0001);
    check_lit("adj_flags", {29'd0, adj, sel, running}, 32'h6);
    sw_sel = 1'b0; idle(S + 2);
    ticks2(2);
    check_lit("adj_0201", 32'(dig_s), 32'h0201);

    // 5: reset press beats a coincident tick at 12:34.
    ticks2(10);
    sw_sel = 1'b1; idle(S + 2);
    ticks2(33);
    sw_adj = 1'b0; idle(S + 2);
    press_pause();
    check_lit("run_1234", 32'(dig_s), 32'h1234);
    btn_reset = 1'b1;
    idle(S + 1);
    step(1'b1, 1'b0);
    check_lit("rst_tick_0000", 32'(dig_s), 32'h0000);
    check_lit("rst_tick_running", {31'd0, running}, 32'h1);
    btn_reset = 1'b0; idle(S + 2);

    // 6: async reset while adjusting at 07:30.
    sw_adj = 1'b1; sw_sel = 1'b0; idle(S + 2);
    ticks2(7);
    sw_sel = 1'b1; idle(S + 2);
    ticks2(30);
    check_lit("adj_0730", 32'(dig_s), 32'h0730);
    rst_n = 1'b0;
    #1;
    check_lit("async_digits", 32'(dig_s), 32'h0000);
    check_lit("async_flags", {29'd0, adj, sel, running}, 32'h1);
    compare_now();
    sw_adj = 1'b0; sw_sel = 1'b0;
    cycle();
    rst_n = 1'b1;
    idle(S + 3);

    // Random soak against the model.
    for (int i = 0; i < 3000; i++) begin
      tick_1hz = ($urandom_range(0, 2) == 0);
      tick_2hz = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0)  btn_pause = ~btn_pause;
      if ($urandom_range(0, 31) == 0) btn_reset = ~btn_reset;
      if ($urandom_range(0, 39) == 0) sw_adj = ~sw_adj;
      if ($urandom_range(0, 5) == 0)  sw_sel = ~sw_sel;
      if ($urandom_range(0, 799) == 0) begin
        rst_n = 1'b0;
        #1;
        compare_now();
      end else begin
        rst_n = 1'b1;
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
